// File: rtl/gpio_edge_event_fifo.sv
// gpio_edge_event_fifo
// Watches the synchronized GPIO pin levels and turns every enabled rising or
// falling edge into a timestamped event {pin, polarity, timestamp}. Events
// wait in a per-pin pending slot, then move into a small FIFO that the
// consumer drains over a valid/ready port. Software can therefore read the
// exact order in which edges happened instead of polling level interrupts.
//
// Flow of one edge:
//   cycle t   : the edge is seen and captured into its pin's pending slot,
//               together with the timestamp value of cycle t
//   cycle t+1 : the arbiter moves the lowest-index pending pin into the FIFO
//   cycle t+2 : the event appears at the FIFO head (when the FIFO was empty)
//
// A second edge on a pin that still has an unserviced pending event is
// dropped. The already stored event is kept and the sticky lost_o flag is
// raised.

module gpio_edge_event_fifo #(
    parameter  int NrGPIOs = 32,
    parameter  int Depth   = 8,
    parameter  int TsWidth = 16,
    localparam int PinW    = $clog2(NrGPIOs),
    localparam int FillW   = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrGPIOs-1:0] gpio_sync_i,
    input  logic [NrGPIOs-1:0] rise_en_i,
    input  logic [NrGPIOs-1:0] fall_en_i,
    input  logic               clear_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [PinW-1:0]    evt_pin_o,
    output logic               evt_rising_o,
    output logic [TsWidth-1:0] evt_ts_o,
    output logic [FillW-1:0]   fill_o,
    output logic               lost_o,
    output logic               irq_o
);

    // One extra pointer bit tells a full FIFO apart from an empty one.
    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    // Free-running timestamp, level history and the priming flag.
    logic [TsWidth-1:0] r_tsCnt;
    logic [NrGPIOs-1:0] r_prev;
    logic               r_primed;

    // Per-pin pending slots. These hold at most one event per pin.
    logic [NrGPIOs-1:0] r_pend;
    logic [NrGPIOs-1:0] r_pendPol;
    logic [TsWidth-1:0] r_pendTs [NrGPIOs];

    // FIFO storage and pointers.
    logic [PinW-1:0]    r_memPin [Depth];
    logic               r_memPol [Depth];
    logic [TsWidth-1:0] r_memTs  [Depth];
    logic [PtrW-1:0]    r_wrPtr;
    logic [PtrW-1:0]    r_rdPtr;
    logic               r_lost;

    // Combinational helpers.
    logic [NrGPIOs-1:0] w_rise;
    logic [NrGPIOs-1:0] w_fall;
    logic [NrGPIOs-1:0] w_edge;
    logic [NrGPIOs-1:0] w_pushMask;
    logic [NrGPIOs-1:0] w_pendKept;
    logic [NrGPIOs-1:0] w_accept;
    logic [NrGPIOs-1:0] w_collide;
    logic               w_anyPend;
    logic [PinW-1:0]    w_pushPin;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [AddrW-1:0]   w_wrAddr;
    logic [AddrW-1:0]   w_rdAddr;

    // Edges only count once the level history has been primed after reset.
    // Without this, the first sampled pin level would look like an edge.
    assign w_rise = gpio_sync_i & ~r_prev & rise_en_i & {NrGPIOs{r_primed}};
    assign w_fall = ~gpio_sync_i & r_prev & fall_en_i & {NrGPIOs{r_primed}};
    assign w_edge = w_rise | w_fall;

    // FIFO status.
    assign w_wrAddr = r_wrPtr[AddrW-1:0];
    assign w_rdAddr = r_rdPtr[AddrW-1:0];
    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AddrW] != r_rdPtr[AddrW]) && (w_wrAddr == w_rdAddr);
    assign w_pop    = !w_empty && evt_ready_i;

    // The arbiter pushes when there is room. A same-cycle pop also counts as
    // room, so a full FIFO keeps moving while the consumer drains it.
    assign w_push     = w_anyPend && (!w_full || w_pop);
    assign w_pushMask = {{(NrGPIOs-1){1'b0}}, w_push} << w_pushPin;

    // A pin that is pushed this cycle frees its slot, so a new edge on that
    // pin re-arms the slot without loss. A pin whose slot stays occupied
    // drops the new edge.
    assign w_pendKept = r_pend & ~w_pushMask;
    assign w_collide  = w_edge & w_pendKept;
    assign w_accept   = w_edge & ~w_pendKept;

    // Find the lowest-index pending pin. This fixes the order in which
    // simultaneous edges enter the FIFO.
    always_comb begin
        w_anyPend = 1'b0;
        w_pushPin = '0;
        for (int i = NrGPIOs - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_anyPend = 1'b1;
                w_pushPin = PinW'(i);
            end
        end
    end

    // Free-running timestamp and pin history. clear_i does not affect either,
    // so clearing never creates a false edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tsCnt  <= '0;
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_tsCnt  <= r_tsCnt + 1'b1;
            r_prev   <= gpio_sync_i;
            r_primed <= 1'b1;
        end
    end

    // Pending-slot occupancy and the sticky loss flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_lost <= 1'b0;
        end else if (clear_i) begin
            r_pend <= '0;
            r_lost <= 1'b0;
        end else begin
            r_pend <= w_pendKept | w_edge;
            if (|w_collide) begin
                r_lost <= 1'b1;
            end
        end
    end

    // Polarity and timestamp of newly accepted edges. These are only
    // meaningful while the matching pending bit is set.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrGPIOs; i++) begin
            if (w_accept[i]) begin
                r_pendPol[i] <= w_rise[i];
                r_pendTs[i]  <= r_tsCnt;
            end
        end
    end

    // FIFO pointers. A clear empties the FIFO and overrides any same-cycle
    // push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // FIFO storage. The pointers alone decide which entries are valid, so the
    // storage has no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_memPin[w_wrAddr] <= w_pushPin;
            r_memPol[w_wrAddr] <= r_pendPol[w_pushPin];
            r_memTs[w_wrAddr]  <= r_pendTs[w_pushPin];
        end
    end

    // Head fields are forced to zero while the FIFO is empty. This gives clean
    // all-zero outputs after reset or clear.
    assign evt_valid_o  = !w_empty;
    assign evt_pin_o    = w_empty ? '0   : r_memPin[w_rdAddr];
    assign evt_rising_o = w_empty ? 1'b0 : r_memPol[w_rdAddr];
    assign evt_ts_o     = w_empty ? '0   : r_memTs[w_rdAddr];
    assign fill_o       = FillW'(r_wrPtr - r_rdPtr);
    assign lost_o       = r_lost;
    assign irq_o        = !w_empty;

endmodule

// File: tb/tb_gpio_edge_event_fifo.sv
// tb_gpio_edge_event_fifo
// Directed scenarios followed by randomized traffic. The bench keeps a
// queue-based reference model of the event FIFO. Every cycle it compares the
// DUT against that model, and the directed scenarios add checks against
// fixed expected values.

module tb_gpio_edge_event_fifo;

    localparam int NrGPIOs = 32;
    localparam int Depth   = 8;
    localparam int TsWidth = 16;
    localparam int PinW    = 5;
    localparam int FillW   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NrGPIOs-1:0] gpioSync;
    logic [NrGPIOs-1:0] riseEn;
    logic [NrGPIOs-1:0] fallEn;
    logic               clear;
    logic               ready;
    logic               evtValid;
    logic [PinW-1:0]    evtPin;
    logic               evtRising;
    logic [TsWidth-1:0] evtTs;
    logic [FillW-1:0]   fill;
    logic               lost;
    logic               irq;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic [PinW-1:0]    pin;
        logic               rising;
        logic [TsWidth-1:0] ts;
    } evt_t;

    // Reference model state
    evt_t               mQ[$];
    logic [NrGPIOs-1:0] mPrev;
    logic               mPrimed;
    logic [TsWidth-1:0] mTs;
    logic [NrGPIOs-1:0] mPendV;
    logic [NrGPIOs-1:0] mPendPol;
    logic [TsWidth-1:0] mPendTs [NrGPIOs];
    logic               mLost;

    always #5 clk = ~clk;

    gpio_edge_event_fifo #(
        .NrGPIOs (NrGPIOs),
        .Depth   (Depth),
        .TsWidth (TsWidth)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .gpio_sync_i  (gpioSync),
        .rise_en_i    (riseEn),
        .fall_en_i    (fallEn),
        .clear_i      (clear),
        .evt_valid_o  (evtValid),
        .evt_ready_i  (ready),
        .evt_pin_o    (evtPin),
        .evt_rising_o (evtRising),
        .evt_ts_o     (evtTs),
        .fill_o       (fill),
        .lost_o       (lost),
        .irq_o        (irq)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the reference model by one clock using the current inputs
    task automatic modelStep();
        logic [NrGPIOs-1:0] rise;
        logic [NrGPIOs-1:0] fall;
        logic [NrGPIOs-1:0] edges;
        int   p;
        bit   popDo;
        bit   pushDo;
        evt_t e;
        if (rst) begin
            mQ.delete();
            mPendV  = '0;
            mLost   = 1'b0;
            mPrev   = '0;
            mPrimed = 1'b0;
            mTs     = '0;
            return;
        end
        rise  = mPrimed ? (gpioSync & ~mPrev & riseEn) : '0;
        fall  = mPrimed ? (~gpioSync & mPrev & fallEn) : '0;
        edges = rise | fall;
        popDo = (mQ.size() > 0) && ready;
        p = -1;
        for (int i = 0; i < NrGPIOs; i++) begin
            if (mPendV[i]) begin
                p = i;
                break;
            end
        end
        pushDo = (p >= 0) && ((mQ.size() < Depth) || popDo);
        if (clear) begin
            mQ.delete();
            mPendV = '0;
            mLost  = 1'b0;
        end else begin
            if (popDo) begin
                e = mQ.pop_front();
            end
            if (pushDo) begin
                e.pin    = PinW'(p);
                e.rising = mPendPol[p];
                e.ts     = mPendTs[p];
                mQ.push_back(e);
                mPendV[p] = 1'b0;
            end
            for (int i = 0; i < NrGPIOs; i++) begin
                if (edges[i]) begin
                    if (mPendV[i]) begin
                        mLost = 1'b1;
                    end else begin
                        mPendV[i]   = 1'b1;
                        mPendPol[i] = rise[i];
                        mPendTs[i]  = mTs;
                    end
                end
            end
        end
        mPrev   = gpioSync;
        mPrimed = 1'b1;
        mTs     = mTs + 1'b1;
    endtask

    // One clock with the current inputs; DUT sampled 1ns after the edge vs model
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("valid", evtValid, mQ.size() != 0);
        checkOutput("irq", irq, mQ.size() != 0);
        checkOutput("fill", fill, mQ.size());
        checkOutput("lost", lost, mLost);
        if (mQ.size() != 0) begin
            checkOutput("head_pin", evtPin, mQ[0].pin);
            checkOutput("head_rising", evtRising, mQ[0].rising);
            checkOutput("head_ts", evtTs, mQ[0].ts);
        end
    endtask

    task automatic doReset();
        rst   = 1'b1;
        clear = 1'b0;
        applyStimulus();
        rst = 1'b0;
    endtask

    logic [TsWidth-1:0] tsSave;
    logic [TsWidth-1:0] expTs;
    logic [NrGPIOs-1:0] toggle;
    int                 readyThresh [3] = '{1, 4, 7};

    initial begin
        rst      = 1'b1;
        gpioSync = '1;
        riseEn   = '1;
        fallEn   = '1;
        clear    = 1'b0;
        ready    = 1'b0;

        // Reset with all pins high: no events after release
        doReset();
        checkOutput("rst_valid", evtValid, 0);
        checkOutput("rst_fill", fill, 0);
        checkOutput("rst_lost", lost, 0);
        checkOutput("rst_pin", evtPin, 0);
        checkOutput("rst_ts", evtTs, 0);
        checkOutput("rst_irq", irq, 0);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("prime_valid", evtValid, 0);
        checkOutput("prime_fill", fill, 0);
        checkOutput("prime_lost", lost, 0);

        // Pin 5 rises at ts 0x0010: event visible two cycles later
        gpioSync = '0;
        doReset();
        riseEn = 32'h0000_0020;
        fallEn = '0;
        while (mTs != 16'h0010) applyStimulus();
        gpioSync[5] = 1'b1;
        applyStimulus();
        checkOutput("p5_lat1_valid", evtValid, 0);
        applyStimulus();
        checkOutput("p5_valid", evtValid, 1);
        checkOutput("p5_pin", evtPin, 5);
        checkOutput("p5_rising", evtRising, 1);
        checkOutput("p5_ts", evtTs, 16'h0010);

        // Pins 3 and 7 rise together: pin 3 first, equal timestamps
        gpioSync = '0;
        doReset();
        riseEn = '1;
        fallEn = '1;
        ready  = 1'b0;
        applyStimulus();
        applyStimulus();
        tsSave   = mTs;
        gpioSync = 32'h0000_0088;
        applyStimulus();
        applyStimulus();
        checkOutput("p37_first_pin", evtPin, 3);
        checkOutput("p37_first_ts", evtTs, tsSave);
        checkOutput("p37_fill1", fill, 1);
        applyStimulus();
        checkOutput("p37_fill2", fill, 2);
        ready = 1'b1;
        applyStimulus();
        checkOutput("p37_second_pin", evtPin, 7);
        checkOutput("p37_second_ts", evtTs, tsSave);
        checkOutput("p37_second_rising", evtRising, 1);
        applyStimulus();
        ready = 1'b0;

        // Nine edges with ready low: FIFO fills, ninth held, collision sets lost
        gpioSync = '0;
        doReset();
        applyStimulus();
        applyStimulus();
        for (int k = 0; k < 9; k++) begin
            gpioSync[k] = 1'b1;
            applyStimulus();
        end
        applyStimulus();
        checkOutput("full_fill", fill, 8);
        checkOutput("full_lost0", lost, 0);
        gpioSync[8] = 1'b0;
        applyStimulus();
        checkOutput("full_lost1", lost, 1);
        checkOutput("full_fill_hold", fill, 8);
        checkOutput("full_head0", evtPin, 0);
        ready = 1'b1;
        for (int j = 1; j < 9; j++) begin
            applyStimulus();
            checkOutput("full_order", evtPin, j);
        end
        checkOutput("full_last_rising", evtRising, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("full_drained", fill, 0);

        // Toggle pin 0 every cycle with ready high: alternating polarity, ts step 1
        gpioSync = '0;
        doReset();
        ready = 1'b1;
        applyStimulus();
        applyStimulus();
        tsSave = mTs;
        for (int k = 0; k < 12; k++) begin
            gpioSync[0] = ~gpioSync[0];
            applyStimulus();
            if (k >= 1) begin
                expTs = tsSave + TsWidth'(k - 1);
                checkOutput("tog_valid", evtValid, 1);
                checkOutput("tog_fill", fill, 1);
                checkOutput("tog_pin", evtPin, 0);
                checkOutput("tog_rising", evtRising, ((k - 1) % 2) == 0);
                checkOutput("tog_ts", evtTs, expTs);
            end
        end
        checkOutput("tog_lost", lost, 0);

        // clear with fill 4 and lost set
        gpioSync = '0;
        doReset();
        ready = 1'b0;
        applyStimulus();
        applyStimulus();
        gpioSync = 32'h0000_0006;
        applyStimulus();
        gpioSync = 32'h0000_0002;
        applyStimulus();
        applyStimulus();
        gpioSync = 32'h0000_001A;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("clr_pre_fill", fill, 4);
        checkOutput("clr_pre_lost", lost, 1);
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        checkOutput("clr_fill", fill, 0);
        checkOutput("clr_valid", evtValid, 0);
        checkOutput("clr_lost", lost, 0);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("clr_no_spurious", evtValid, 0);

        // Randomized traffic, three phases with different consumer speeds
        gpioSync = '0;
        doReset();
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 700; n++) begin
                toggle = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 1) == 0) toggle = toggle & 32'h0000_00FF;
                gpioSync = gpioSync ^ toggle;
                if ($urandom_range(0, 31) == 0) begin
                    riseEn = $urandom | $urandom;
                    fallEn = $urandom | $urandom;
                end
                ready = ($urandom_range(0, 7) < readyThresh[ph]);
                clear = ($urandom_range(0, 63) == 0);
                rst   = ($urandom_range(0, 399) == 0);
                applyStimulus();
            end
        end
        rst   = 1'b0;
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
